prog_loader: RTL and testbench

- Writer side of the instruction-memory interface: receives a serial bitstream, assembles 9-bit instruction words and writes them into instruction memory at consecutive addresses.
- The controller is the reader side; it fetches these words and drives output_data.
- cpu_hold stalls the controller while a load is in progress.
- A load session is one header word (word count N) followed by N data words.

---
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial program loader: assembles LSB-first 9-bit words from a bitstream and writes them to
// instruction memory after a word-count header, holding the CPU while the load runs.
module prog_loader #(
  parameter int unsigned WORD_W = 9,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned CntW = $clog2(WORD_W);
  localparam logic [WORD_W:0] DepthCmp = (WORD_W+1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_asm;
  logic [WORD_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              accept, last_bit, hdr_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
    end
  end

  // Word as it will look once this cycle's bit lands; the header check needs it immediately.
  always_comb begin
    word_asm           = shift_q;
    word_asm[bit_cnt_q] = in_bit;
  end

  assign accept   = in_valid & in_ready;
  assign last_bit = (bit_cnt_q == CntW'(WORD_W - 1));
  assign hdr_bad  = (word_asm == '0) || ({1'b0, word_asm} > DepthCmp);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    words_d     = words_q;
    if (start) begin
      state_d   = StHdr;
      bit_cnt_d = '0;
      addr_d    = '0;
      words_d   = '0;
    end else begin
      unique case (state_q)
        StHdr, StData: begin
          if (accept) begin
            shift_d = word_asm;
            if (last_bit) begin
              bit_cnt_d = '0;
              if (state_q == StData) begin
                state_d = StWrite;
              end else if (hdr_bad) begin
                state_d = StErr;
              end else begin
                remaining_d = word_asm;
                state_d     = StData;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          addr_d      = addr_q + ADDR_W'(1);
          words_d     = words_q + (ADDR_W+1)'(1);
          remaining_d = remaining_q - WORD_W'(1);
          state_d     = (remaining_q == WORD_W'(1)) ? StDone : StData;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    mem_we   = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StHdr, StData: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      StWrite: begin
        cpu_hold = 1'b1;
        mem_we   = 1'b1;
      end
      StDone:  done  = 1'b1;
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = shift_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load sessions, random sessions checked against a simple
// write-list model, and hand-built reset/restart sequences.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_bit, in_valid;
  logic       in_ready, mem_we, cpu_hold, done, error;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic [8:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [8:0]  dat [0:255];
  logic [16:0] got [$];

  prog_loader #(.WORD_W(9), .ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) got.push_back({mem_addr, mem_wdata});

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: a valid header N yields N writes, word i at address i; anything else yields none.
  function automatic int model_count(input logic [8:0] n);
    return (n >= 1 && n <= 256) ? int'(n) : 0;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    int t = 0;
    int g = (gap > 0) ? $urandom_range(0, gap) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_bit   = 1'($urandom);
      @(negedge clk);
    end
    in_bit   = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [8:0] w, input int gap);
    for (int k = 0; k < 9; k++) send_bit(w[k], gap);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic session(input logic [8:0] hdr, input int gap, input bit e_err,
                         input bit e_done, input int e_ww, input string tag);
    got.delete();
    pulse_start();
    check({tag, ":hold_after_start"}, cpu_hold, 1);
    check({tag, ":flags_cleared"}, {done, error}, 0);
    send_word(hdr, gap);
    if (!e_done) begin
      check({tag, ":error"}, error, e_err);
      check({tag, ":ready_after_hdr"}, in_ready, 0);
      check({tag, ":hold_after_hdr"}, cpu_hold, 0);
    end else begin
      for (int i = 0; i < e_ww; i++) begin
        send_word(dat[i], gap);
        check({tag, ":we_latency"}, mem_we, 1);
        check({tag, ":addr"}, mem_addr, i % 256);
        check({tag, ":wdata"}, mem_wdata, dat[i]);
        check({tag, ":ready_in_write"}, in_ready, 0);
      end
      @(negedge clk);
      check({tag, ":done"}, done, 1);
      check({tag, ":error"}, error, 0);
      check({tag, ":words_written"}, words_written, e_ww);
      check({tag, ":final_addr"}, mem_addr, e_ww % 256);
      check({tag, ":hold_done"}, cpu_hold, 0);
    end
    repeat (2) @(negedge clk);
    check({tag, ":nwrites"}, got.size(), e_ww);
    for (int i = 0; i < got.size() && i < e_ww; i++)
      check({tag, ":write"}, got[i], {8'(i), dat[i]});
  endtask

  typedef struct {
    logic [8:0] hdr;
    logic [8:0] d0, d1, d2;
    int         gap;
    bit         e_err;
    bit         e_done;
    int         e_ww;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic ok_idle;
    vecs[0] = '{9'd3,   9'h1A5, 9'h0FF, 9'h100, 0, 1'b0, 1'b1, 3};
    vecs[1] = '{9'd0,   9'h000, 9'h000, 9'h000, 0, 1'b1, 1'b0, 0};
    vecs[2] = '{9'd257, 9'h000, 9'h000, 9'h000, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{9'd2,   9'h155, 9'h0AA, 9'h000, 4, 1'b0, 1'b1, 2};
    vecs[4] = '{9'd1,   9'h1FF, 9'h000, 9'h000, 2, 1'b0, 1'b1, 1};

    reset = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ok_idle = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_written} != 0)
        ok_idle = 1'b0;
    end
    check("reset_idle_outputs_zero", ok_idle, 1);

    for (int v = 0; v < 5; v++) begin
      dat[0] = vecs[v].d0; dat[1] = vecs[v].d1; dat[2] = vecs[v].d2;
      session(vecs[v].hdr, vecs[v].gap, vecs[v].e_err, vecs[v].e_done, vecs[v].e_ww,
              $sformatf("vec%0d", v));
    end

    // Reset after 5 bits of the second data word: no further writes, back to idle.
    for (int i = 0; i < 4; i++) dat[i] = 9'(i * 37 + 5);
    got.delete();
    pulse_start();
    send_word(9'd4, 0);
    send_word(dat[0], 0);
    for (int k = 0; k < 5; k++) send_bit(dat[1][k], 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid:we", mem_we, 0);
    check("rst_mid:idle", {in_ready, cpu_hold, done, error}, 0);
    check("rst_mid:counters", {mem_addr, words_written}, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid:nwrites", got.size(), 1);
    session(9'd4, 1, 1'b0, 1'b1, 4, "rst_reload");

    // Restart mid-DATA after one of three words.
    pulse_start();
    send_word(9'd3, 0);
    send_word(9'h0C3, 0);
    @(negedge clk);
    pulse_start();
    check("restart:in_hdr", {in_ready, cpu_hold}, 2'b11);
    check("restart:cleared", {done, error, words_written, mem_addr}, 0);
    dat[0] = 9'h13C;
    session(9'd1, 0, 1'b0, 1'b1, 1, "restart_n1");

    // Random sessions, expectations from the write-list model.
    for (int r = 0; r < 6; r++) begin
      logic [8:0] n;
      int cnt;
      n = (r == 2) ? 9'($urandom_range(257, 511)) : 9'($urandom_range(1, 8));
      cnt = model_count(n);
      for (int i = 0; i < 8; i++) dat[i] = 9'($urandom);
      session(n, $urandom_range(0, 4), cnt == 0, cnt != 0, cnt, $sformatf("rnd%0d", r));
    end

    // Full-depth load: address wraps to 0, count carries 256.
    for (int i = 0; i < 256; i++) dat[i] = 9'($urandom);
    session(9'd256, 0, 1'b0, 1'b1, model_count(9'd256), "full_depth");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
